// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources in, pipeline controls,
// watchdog flag and performance counters out. master = pipeline, slave = ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_jb;
  logic             ex_muldiv_start;
  logic             muldiv_done;
  logic             im_stall;
  logic             dm_stall;
  logic             cacheStall;
  logic             jb;
  logic             stall;
  logic             pc_we;
  logic             hang_err;
  logic [CNT_W-1:0] cnt_load_use;
  logic [CNT_W-1:0] cnt_flush;
  logic [CNT_W-1:0] cnt_freeze;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_is_load, ex_jb, ex_muldiv_start,
    output muldiv_done, im_stall, dm_stall,
    input  cacheStall, jb, stall, pc_we, hang_err,
    input  cnt_load_use, cnt_flush, cnt_freeze
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_is_load, ex_jb, ex_muldiv_start,
    input  muldiv_done, im_stall, dm_stall,
    output cacheStall, jb, stall, pc_we, hang_err,
    output cnt_load_use, cnt_flush, cnt_freeze
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, EX branch flush, cache/muldiv freeze,
// freeze watchdog and perf counters. Ports: clk, rst (sync, low), hz (slave).
module hazard_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input logic      clk,
  input logic      rst,
  hazard_ctrl_if.slave hz
);
  localparam int FW = $clog2(TIMEOUT) + 1;
  localparam logic [FW-1:0] TO_V = FW'(TIMEOUT);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MD_WAIT = 2'd1;
  localparam logic [1:0] MD_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    frz_run_q, frz_run_d;
  logic             hang_q, hang_d;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
  logic [CNT_W-1:0] cnt_fl_q, cnt_fl_d;
  logic [CNT_W-1:0] cnt_fz_q, cnt_fz_d;

  logic lu, cache, md_freeze, freeze;
  logic jb_o, stall_o;

  always_comb begin
    lu = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
         ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
          (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    cache = hz.im_stall || hz.dm_stall;
    md_freeze = ((state_q == RUN) && hz.ex_muldiv_start) ||
                ((state_q == MD_WAIT) && !hz.muldiv_done);
    freeze  = cache || md_freeze;
    jb_o    = hz.ex_jb && !freeze;
    stall_o = lu && !freeze && !hz.ex_jb;
  end

  // A cache miss blocks the muldiv launch; a done that lands under a
  // cache miss parks in MD_HOLD so the held start cannot relaunch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:
        if (hz.ex_muldiv_start && !cache) state_d = MD_WAIT;
      MD_WAIT:
        if (hz.muldiv_done) state_d = cache ? MD_HOLD : RUN;
      MD_HOLD:
        if (!cache) state_d = RUN;
      default:
        state_d = RUN;
    endcase
  end

  always_comb begin
    frz_run_d = '0;
    if (freeze)
      frz_run_d = (frz_run_q == TO_V) ? TO_V : frz_run_q + 1'b1;
    hang_d   = hang_q || (frz_run_d == TO_V);
    cnt_lu_d = cnt_lu_q + CNT_W'(stall_o);
    cnt_fl_d = cnt_fl_q + CNT_W'(jb_o);
    cnt_fz_d = cnt_fz_q + CNT_W'(freeze);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      frz_run_q <= '0;
      hang_q    <= 1'b0;
      cnt_lu_q  <= '0;
      cnt_fl_q  <= '0;
      cnt_fz_q  <= '0;
    end else begin
      state_q   <= state_d;
      frz_run_q <= frz_run_d;
      hang_q    <= hang_d;
      cnt_lu_q  <= cnt_lu_d;
      cnt_fl_q  <= cnt_fl_d;
      cnt_fz_q  <= cnt_fz_d;
    end
  end

  assign hz.cacheStall   = freeze;
  assign hz.jb           = jb_o;
  assign hz.stall        = stall_o;
  assign hz.pc_we        = !freeze && !stall_o;
  assign hz.hang_err     = hang_q;
  assign hz.cnt_load_use = cnt_lu_q;
  assign hz.cnt_flush    = cnt_fl_q;
  assign hz.cnt_freeze   = cnt_fz_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-value queue and a small
// reference model of the watchdog and counters.
module tb_hazard_ctrl;
  localparam int TO = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hz();

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  typedef struct {
    string          tag;
    logic           cs, jb, st, pcwe, hang;
    logic [CW-1:0]  clu, cfl, cfz;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int m_run = 0;
  logic m_hang = 1'b0;
  logic [CW-1:0] m_lu = '0;
  logic [CW-1:0] m_fl = '0;
  logic [CW-1:0] m_fz = '0;

  task automatic chk(string tag, string f,
                     logic [CW-1:0] obs, logic [CW-1:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, ex);
    end
  endtask

  task automatic idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0;
    hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_is_load = 1'b0;
    hz.ex_jb = 1'b0; hz.ex_muldiv_start = 1'b0;
    hz.muldiv_done = 1'b0;
    hz.im_stall = 1'b0; hz.dm_stall = 1'b0;
  endtask

  task automatic step(string tag, logic cs, logic jb, logic st);
    exp_t e, g;
    e.tag = tag; e.cs = cs; e.jb = jb; e.st = st;
    e.pcwe = !cs && !st;
    e.hang = m_hang;
    e.clu = m_lu; e.cfl = m_fl; e.cfz = m_fz;
    sbq.push_back(e);
    #1;
    g = sbq.pop_front();
    chk(g.tag, "cacheStall", CW'(hz.cacheStall), CW'(g.cs));
    chk(g.tag, "jb",         CW'(hz.jb),         CW'(g.jb));
    chk(g.tag, "stall",      CW'(hz.stall),      CW'(g.st));
    chk(g.tag, "pc_we",      CW'(hz.pc_we),      CW'(g.pcwe));
    chk(g.tag, "hang_err",   CW'(hz.hang_err),   CW'(g.hang));
    chk(g.tag, "cnt_lu",     hz.cnt_load_use,    g.clu);
    chk(g.tag, "cnt_flush",  hz.cnt_flush,       g.cfl);
    chk(g.tag, "cnt_freeze", hz.cnt_freeze,      g.cfz);
    if (!rst) begin
      m_run = 0; m_hang = 1'b0;
      m_lu = '0; m_fl = '0; m_fz = '0;
    end else begin
      m_lu += CW'(st);
      m_fl += CW'(jb);
      m_fz += CW'(cs);
      if (cs) m_run = (m_run < TO) ? m_run + 1 : TO;
      else    m_run = 0;
      if (m_run == TO) m_hang = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    step("rst_idle", 0, 0, 0);
    hz.ex_muldiv_start = 1'b1;
    step("rst_md", 1, 0, 0);
    hz.im_stall = 1'b1;
    step("rst_im", 1, 0, 0);
    idle();
    rst = 1'b1;
    step("idle", 0, 0, 0);

    // load-use on rs2
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5;
    hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
    step("lu_rs2", 0, 0, 1);
    hz.ex_is_load = 1'b0;
    step("lu_bubble", 0, 0, 0);
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0;
    step("lu_x0", 0, 0, 0);
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd7;
    hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1'b1;
    step("lu_rs1", 0, 0, 1);
    hz.id_use_rs1 = 1'b0;
    step("lu_nouse", 0, 0, 0);
    hz.id_use_rs1 = 1'b1; hz.ex_is_load = 1'b0;
    step("lu_noload", 0, 0, 0);

    // priority freeze > jb > stall
    hz.ex_is_load = 1'b1; hz.ex_jb = 1'b1;
    step("pri_jb", 0, 1, 0);
    hz.dm_stall = 1'b1;
    step("pri_frz", 1, 0, 0);
    idle();

    // jb held through an I-miss fires once unfrozen
    hz.ex_jb = 1'b1; hz.im_stall = 1'b1;
    step("jb_frz0", 1, 0, 0);
    step("jb_frz1", 1, 0, 0);
    hz.im_stall = 1'b0;
    step("jb_rel", 0, 1, 0);
    idle();
    step("jb_done", 0, 0, 0);

    // muldiv, done 4 cycles after start
    hz.ex_muldiv_start = 1'b1;
    step("md_c0", 1, 0, 0);
    step("md_c1", 1, 0, 0);
    step("md_c2", 1, 0, 0);
    step("md_c3", 1, 0, 0);
    hz.muldiv_done = 1'b1;
    step("md_done", 0, 0, 0);
    idle();
    hz.muldiv_done = 1'b1;
    step("md_done_run", 0, 0, 0);
    idle();
    hz.ex_muldiv_start = 1'b1;
    step("md1_c0", 1, 0, 0);
    hz.muldiv_done = 1'b1;
    step("md1_done", 0, 0, 0);
    idle();
    step("md_idle", 0, 0, 0);

    // done lands under a D-miss: hold, then no relaunch
    hz.ex_muldiv_start = 1'b1;
    step("ov_c0", 1, 0, 0);
    step("ov_c1", 1, 0, 0);
    hz.muldiv_done = 1'b1; hz.dm_stall = 1'b1;
    step("ov_c2", 1, 0, 0);
    hz.muldiv_done = 1'b0;
    step("ov_c3", 1, 0, 0);
    step("ov_c4", 1, 0, 0);
    hz.dm_stall = 1'b0;
    step("ov_rel", 0, 0, 0);
    idle();
    step("ov_idle", 0, 0, 0);

    // watchdog: 7 cycles is safe, 8 trips
    hz.im_stall = 1'b1;
    repeat (7) step("wd7", 1, 0, 0);
    hz.im_stall = 1'b0;
    step("wd7_end", 0, 0, 0);
    hz.im_stall = 1'b1;
    repeat (8) step("wd8", 1, 0, 0);
    hz.im_stall = 1'b0;
    step("wd8_end", 0, 0, 0);
    step("wd8_sticky", 0, 0, 0);

    // reset in MD_WAIT with start held
    hz.ex_muldiv_start = 1'b1;
    step("rw_c0", 1, 0, 0);
    step("rw_c1", 1, 0, 0);
    rst = 1'b0;
    step("rw_rst", 1, 0, 0);
    rst = 1'b1;
    step("rw_re0", 1, 0, 0);
    step("rw_re1", 1, 0, 0);
    hz.muldiv_done = 1'b1;
    step("rw_done", 0, 0, 0);
    idle();
    step("rw_idle", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
